mem_port_arbiter: RTL and testbench

- Sequences and shares the single-port data/instruction memory between the stack processor (cpu port) and a debug/program-loader port (dbg port).
- Each requester issues one read or write transaction per request.
- The arbiter serialises transactions, drives the memory for a fixed access latency, returns read data and pulses an acknowledge.
- Sits between the processor's DataPath memory interface and the memory array in the Processor top level.

---
 rtl/mem_port_arbiter_if.sv | 47 ++++
 rtl/mem_port_arbiter.sv | 119 +++++++++++
 tb/tb_mem_port_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundles the cpu, debug and memory-side signals of the memory port arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the memory array.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_ack;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  logic [1:0]        owner;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_rdata, dbg_ack,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata,
    output owner
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_rdata, dbg_ack,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata,
    input  owner
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the cpu and the debug/loader port,
// one serialised transaction at a time with a fixed access latency.
module mem_port_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 8,
  parameter int MEM_LAT  = 1,
  parameter int CPU_PRIO = 0
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic              last;
  logic [1:0]        owner;
  logic              cpu_ack, dbg_ack;
  logic [DATA_W-1:0] cpu_rdata, dbg_rdata;

  logic              we_l;
  logic [ADDR_W-1:0] addr_l;
  logic [DATA_W-1:0] wdata_l;

  logic              grant_cpu, grant_dbg, finish;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // On a tie, last=1 means dbg was served most recently, so cpu goes next.
  always_comb begin
    state_nx  = state;
    grant_cpu = 1'b0;
    grant_dbg = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cpu_req && bus.dbg_req) begin
          if (CPU_PRIO != 0 || last) grant_cpu = 1'b1;
          else                       grant_dbg = 1'b1;
        end else if (bus.cpu_req) begin
          grant_cpu = 1'b1;
        end else if (bus.dbg_req) begin
          grant_dbg = 1'b1;
        end
        if (grant_cpu || grant_dbg) state_nx = BUSY;
      end
      BUSY: begin
        if (cnt == '0) begin
          finish   = 1'b1;
          state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      last      <= 1'b1;
      owner     <= 2'b00;
      cpu_ack   <= 1'b0;
      dbg_ack   <= 1'b0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
    end else begin
      cpu_ack <= finish && owner[0];
      dbg_ack <= finish && owner[1];
      if (grant_cpu || grant_dbg) begin
        cnt   <= CNT_START;
        owner <= grant_dbg ? 2'b10 : 2'b01;
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end else if (state == DONE) begin
        owner <= 2'b00;
      end
      if (finish) begin
        last <= owner[1];
        if (!we_l) begin
          if (owner[1]) dbg_rdata <= bus.mem_rdata;
          else          cpu_rdata <= bus.mem_rdata;
        end
      end
    end
  end

  // Transaction fields are frozen at grant; later port activity cannot disturb them.
  always_ff @(posedge clk) begin
    if (grant_cpu) begin
      we_l    <= bus.cpu_we;
      addr_l  <= bus.cpu_addr;
      wdata_l <= bus.cpu_wdata;
    end else if (grant_dbg) begin
      we_l    <= bus.dbg_we;
      addr_l  <= bus.dbg_addr;
      wdata_l <= bus.dbg_wdata;
    end
  end

  assign bus.mem_addr  = (state == BUSY) ? addr_l  : '0;
  assign bus.mem_wdata = (state == BUSY) ? wdata_l : '0;
  assign bus.mem_we    = (state == BUSY) && (cnt == CNT_START) && we_l;

  assign bus.cpu_ack   = cpu_ack;
  assign bus.dbg_ack   = dbg_ack;
  assign bus.cpu_rdata = cpu_rdata;
  assign bus.dbg_rdata = dbg_rdata;
  assign bus.owner     = owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table at MEM_LAT=1,
// then hand-written sequences at MEM_LAT=3 and with CPU_PRIO=1.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1 = 1'b1, rst3 = 1'b1, rstp = 1'b1;
  logic mem_load = 1'b1;

  mem_port_arbiter_if #(.ADDR_W(5), .DATA_W(8)) b1 ();
  mem_port_arbiter_if #(.ADDR_W(5), .DATA_W(8)) b3 ();
  mem_port_arbiter_if #(.ADDR_W(5), .DATA_W(8)) bp ();

  mem_port_arbiter #(.ADDR_W(5), .DATA_W(8), .MEM_LAT(1), .CPU_PRIO(0))
    u_l1 (.clk(clk), .reset(rst1), .bus(b1));
  mem_port_arbiter #(.ADDR_W(5), .DATA_W(8), .MEM_LAT(3), .CPU_PRIO(0))
    u_l3 (.clk(clk), .reset(rst3), .bus(b3));
  mem_port_arbiter #(.ADDR_W(5), .DATA_W(8), .MEM_LAT(1), .CPU_PRIO(1))
    u_pr (.clk(clk), .reset(rstp), .bus(bp));

  logic [7:0] mem1 [32];
  logic [7:0] mem3 [32];
  logic [7:0] memp [32];

  function automatic logic [7:0] preset(input int i);
    case (i)
      3:       return 8'hA5;
      7:       return 8'h5A;
      default: return 8'(8'h40 + i);
    endcase
  endfunction

  assign b1.mem_rdata = mem1[b1.mem_addr];
  assign b3.mem_rdata = mem3[b3.mem_addr];
  assign bp.mem_rdata = memp[bp.mem_addr];

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 32; i++) begin
        mem1[i] <= preset(i);
        mem3[i] <= preset(i);
        memp[i] <= preset(i);
      end
    end else begin
      if (b1.mem_we) mem1[b1.mem_addr] <= b1.mem_wdata;
      if (b3.mem_we) mem3[b3.mem_addr] <= b3.mem_wdata;
      if (bp.mem_we) memp[bp.mem_addr] <= bp.mem_wdata;
    end
  end

  typedef struct {
    logic       rst;
    logic       creq, cwe;
    logic [4:0] caddr;
    logic [7:0] cwd;
    logic       dreq, dwe;
    logic [4:0] daddr;
    logic [7:0] dwd;
    logic       cack, dack;
    logic [7:0] crd, drd;
    logic [1:0] own;
    logic       mwe;
    logic [4:0] madr;
    logic [7:0] mwd;
  } vec_t;

  vec_t vecs[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic add(input logic rst, input logic creq, input logic cwe, input logic [4:0] caddr,
                     input logic [7:0] cwd, input logic dreq, input logic dwe, input logic [4:0] daddr,
                     input logic [7:0] dwd, input logic cack, input logic dack, input logic [7:0] crd,
                     input logic [7:0] drd, input logic [1:0] own, input logic mwe,
                     input logic [4:0] madr, input logic [7:0] mwd);
    vec_t v;
    v.rst = rst; v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
    v.dreq = dreq; v.dwe = dwe; v.daddr = daddr; v.dwd = dwd;
    v.cack = cack; v.dack = dack; v.crd = crd; v.drd = drd;
    v.own = own; v.mwe = mwe; v.madr = madr; v.mwd = mwd;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cpu_acks;
    b1.cpu_req = 0; b1.cpu_we = 0; b1.cpu_addr = 0; b1.cpu_wdata = 0;
    b1.dbg_req = 0; b1.dbg_we = 0; b1.dbg_addr = 0; b1.dbg_wdata = 0;
    b3.cpu_req = 0; b3.cpu_we = 0; b3.cpu_addr = 0; b3.cpu_wdata = 0;
    b3.dbg_req = 0; b3.dbg_we = 0; b3.dbg_addr = 0; b3.dbg_wdata = 0;
    bp.cpu_req = 0; bp.cpu_we = 0; bp.cpu_addr = 0; bp.cpu_wdata = 0;
    bp.dbg_req = 0; bp.dbg_we = 0; bp.dbg_addr = 0; bp.dbg_wdata = 0;

    //   rst creq cwe caddr  cwd   dreq dwe daddr  dwd  | cack dack crd    drd    own mwe madr   mwd
    add(1, 0, 0, 5'h00, 8'hEE, 0, 0, 5'h00, 8'h11,  0, 0, 8'h00, 8'h00, 2'd0, 0, 5'h00, 8'h00);
    add(1, 0, 0, 5'h00, 8'hEE, 0, 0, 5'h00, 8'h11,  0, 0, 8'h00, 8'h00, 2'd0, 0, 5'h00, 8'h00);
    add(0, 1, 0, 5'h03, 8'hEE, 0, 0, 5'h00, 8'h11,  0, 0, 8'h00, 8'h00, 2'd1, 0, 5'h03, 8'hEE);
    add(0, 1, 0, 5'h03, 8'hEE, 0, 0, 5'h00, 8'h11,  1, 0, 8'hA5, 8'h00, 2'd1, 0, 5'h00, 8'h00);
    add(0, 0, 0, 5'h03, 8'hEE, 0, 0, 5'h00, 8'h11,  0, 0, 8'hA5, 8'h00, 2'd0, 0, 5'h00, 8'h00);
    add(0, 0, 0, 5'h03, 8'hEE, 1, 1, 5'h1F, 8'h3C,  0, 0, 8'hA5, 8'h00, 2'd2, 1, 5'h1F, 8'h3C);
    add(0, 0, 0, 5'h03, 8'hEE, 1, 1, 5'h02, 8'h77,  0, 1, 8'hA5, 8'h00, 2'd2, 0, 5'h00, 8'h00);
    add(0, 0, 0, 5'h03, 8'hEE, 0, 1, 5'h02, 8'h77,  0, 0, 8'hA5, 8'h00, 2'd0, 0, 5'h00, 8'h00);
    add(0, 1, 0, 5'h1F, 8'hEE, 0, 1, 5'h02, 8'h77,  0, 0, 8'hA5, 8'h00, 2'd1, 0, 5'h1F, 8'hEE);
    add(0, 1, 0, 5'h1F, 8'hEE, 0, 1, 5'h02, 8'h77,  1, 0, 8'h3C, 8'h00, 2'd1, 0, 5'h00, 8'h00);
    add(0, 0, 0, 5'h1F, 8'hEE, 0, 1, 5'h02, 8'h77,  0, 0, 8'h3C, 8'h00, 2'd0, 0, 5'h00, 8'h00);
    add(1, 0, 0, 5'h1F, 8'hEE, 0, 0, 5'h02, 8'h77,  0, 0, 8'h00, 8'h00, 2'd0, 0, 5'h00, 8'h00);
    add(0, 1, 0, 5'h03, 8'hEE, 1, 0, 5'h1F, 8'h11,  0, 0, 8'h00, 8'h00, 2'd1, 0, 5'h03, 8'hEE);
    add(0, 1, 0, 5'h03, 8'hEE, 1, 0, 5'h1F, 8'h11,  1, 0, 8'hA5, 8'h00, 2'd1, 0, 5'h00, 8'h00);
    add(0, 1, 0, 5'h03, 8'hEE, 1, 0, 5'h1F, 8'h11,  0, 0, 8'hA5, 8'h00, 2'd0, 0, 5'h00, 8'h00);
    add(0, 1, 0, 5'h03, 8'hEE, 1, 0, 5'h1F, 8'h11,  0, 0, 8'hA5, 8'h00, 2'd2, 0, 5'h1F, 8'h11);
    add(0, 1, 0, 5'h03, 8'hEE, 1, 0, 5'h1F, 8'h11,  0, 1, 8'hA5, 8'h3C, 2'd2, 0, 5'h00, 8'h00);
    add(0, 1, 0, 5'h03, 8'hEE, 1, 0, 5'h1F, 8'h11,  0, 0, 8'hA5, 8'h3C, 2'd0, 0, 5'h00, 8'h00);
    add(0, 1, 0, 5'h03, 8'hEE, 1, 0, 5'h1F, 8'h11,  0, 0, 8'hA5, 8'h3C, 2'd1, 0, 5'h03, 8'hEE);
    add(0, 1, 0, 5'h03, 8'hEE, 1, 0, 5'h1F, 8'h11,  1, 0, 8'hA5, 8'h3C, 2'd1, 0, 5'h00, 8'h00);
    add(0, 0, 0, 5'h03, 8'hEE, 0, 0, 5'h1F, 8'h11,  0, 0, 8'hA5, 8'h3C, 2'd0, 0, 5'h00, 8'h00);
    add(0, 0, 0, 5'h03, 8'hEE, 0, 0, 5'h1F, 8'h11,  0, 0, 8'hA5, 8'h3C, 2'd0, 0, 5'h00, 8'h00);

    tick();
    mem_load = 1'b0;

    foreach (vecs[i]) begin
      rst1 = vecs[i].rst;
      b1.cpu_req = vecs[i].creq; b1.cpu_we = vecs[i].cwe;
      b1.cpu_addr = vecs[i].caddr; b1.cpu_wdata = vecs[i].cwd;
      b1.dbg_req = vecs[i].dreq; b1.dbg_we = vecs[i].dwe;
      b1.dbg_addr = vecs[i].daddr; b1.dbg_wdata = vecs[i].dwd;
      tick();
      chk($sformatf("v%0d cpu_ack", i),   32'(b1.cpu_ack),   32'(vecs[i].cack));
      chk($sformatf("v%0d dbg_ack", i),   32'(b1.dbg_ack),   32'(vecs[i].dack));
      chk($sformatf("v%0d cpu_rdata", i), 32'(b1.cpu_rdata), 32'(vecs[i].crd));
      chk($sformatf("v%0d dbg_rdata", i), 32'(b1.dbg_rdata), 32'(vecs[i].drd));
      chk($sformatf("v%0d owner", i),     32'(b1.owner),     32'(vecs[i].own));
      chk($sformatf("v%0d mem_we", i),    32'(b1.mem_we),    32'(vecs[i].mwe));
      chk($sformatf("v%0d mem_addr", i),  32'(b1.mem_addr),  32'(vecs[i].madr));
      chk($sformatf("v%0d mem_wdata", i), 32'(b1.mem_wdata), 32'(vecs[i].mwd));
    end

    // MEM_LAT=3 read; address input moves after grant
    rst3 = 1'b0;
    b3.cpu_req = 1; b3.cpu_we = 0; b3.cpu_addr = 5'h07; b3.cpu_wdata = 8'h00;
    tick();
    chk("l3rd owner", 32'(b3.owner), 32'd1);
    b3.cpu_addr = 5'h08;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) tick();
      chk($sformatf("l3rd c%0d mem_addr", c), 32'(b3.mem_addr), 32'h07);
      chk($sformatf("l3rd c%0d mem_we", c),   32'(b3.mem_we),   32'd0);
      chk($sformatf("l3rd c%0d cpu_ack", c),  32'(b3.cpu_ack),  32'd0);
    end
    tick();
    chk("l3rd ack", 32'(b3.cpu_ack), 32'd1);
    chk("l3rd rdata", 32'(b3.cpu_rdata), 32'h5A);
    chk("l3rd done mem_addr", 32'(b3.mem_addr), 32'h00);
    b3.cpu_req = 0;
    tick();
    chk("l3rd idle ack", 32'(b3.cpu_ack), 32'd0);
    chk("l3rd idle owner", 32'(b3.owner), 32'd0);

    // MEM_LAT=3 write: strobe only in the first busy cycle
    b3.cpu_req = 1; b3.cpu_we = 1; b3.cpu_addr = 5'h0A; b3.cpu_wdata = 8'h99;
    tick();
    chk("l3wr c0 mem_we", 32'(b3.mem_we), 32'd1);
    chk("l3wr c0 mem_addr", 32'(b3.mem_addr), 32'h0A);
    chk("l3wr c0 mem_wdata", 32'(b3.mem_wdata), 32'h99);
    tick();
    chk("l3wr c1 mem_we", 32'(b3.mem_we), 32'd0);
    chk("l3wr c1 mem_addr", 32'(b3.mem_addr), 32'h0A);
    tick();
    chk("l3wr c2 mem_we", 32'(b3.mem_we), 32'd0);
    tick();
    chk("l3wr ack", 32'(b3.cpu_ack), 32'd1);
    chk("l3wr rdata kept", 32'(b3.cpu_rdata), 32'h5A);
    b3.cpu_req = 0;
    tick();

    // Reset in the 2nd busy cycle of a MEM_LAT=3 read
    b3.cpu_req = 1; b3.cpu_we = 0; b3.cpu_addr = 5'h07;
    tick();
    chk("l3rst busy1 owner", 32'(b3.owner), 32'd1);
    tick();
    chk("l3rst busy2 owner", 32'(b3.owner), 32'd1);
    rst3 = 1'b1;
    tick();
    chk("l3rst owner", 32'(b3.owner), 32'd0);
    chk("l3rst mem_addr", 32'(b3.mem_addr), 32'h00);
    chk("l3rst cpu_ack", 32'(b3.cpu_ack), 32'd0);
    chk("l3rst cpu_rdata", 32'(b3.cpu_rdata), 32'h00);
    rst3 = 1'b0; b3.cpu_req = 0;
    tick();
    chk("l3rst after ack", 32'(b3.cpu_ack), 32'd0);
    chk("l3rst after owner", 32'(b3.owner), 32'd0);
    b3.dbg_req = 1; b3.dbg_we = 0; b3.dbg_addr = 5'h07;
    tick();
    chk("l3dbg owner", 32'(b3.owner), 32'd2);
    chk("l3dbg mem_addr", 32'(b3.mem_addr), 32'h07);
    tick();
    tick();
    chk("l3dbg early ack", 32'(b3.dbg_ack), 32'd0);
    tick();
    chk("l3dbg ack", 32'(b3.dbg_ack), 32'd1);
    chk("l3dbg cpu_ack", 32'(b3.cpu_ack), 32'd0);
    chk("l3dbg rdata", 32'(b3.dbg_rdata), 32'h5A);
    b3.dbg_req = 0;
    tick();
    chk("l3dbg idle owner", 32'(b3.owner), 32'd0);

    // CPU_PRIO=1: cpu wins every tie
    rstp = 1'b0;
    bp.cpu_req = 1; bp.cpu_we = 0; bp.cpu_addr = 5'h03;
    bp.dbg_req = 1; bp.dbg_we = 0; bp.dbg_addr = 5'h05;
    cpu_acks = 0;
    for (int c = 0; c < 9; c++) begin
      tick();
      chk($sformatf("prio c%0d dbg_ack", c), 32'(bp.dbg_ack), 32'd0);
      chk($sformatf("prio c%0d dbg_owner", c), 32'(bp.owner == 2'b10), 32'd0);
      if (bp.cpu_ack) cpu_acks++;
    end
    chk("prio cpu_ack count", 32'(cpu_acks), 32'd3);
    chk("prio cpu_rdata", 32'(bp.cpu_rdata), 32'hA5);
    bp.cpu_req = 0; bp.dbg_req = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
